opc7_membus: RTL and testbench

Bus bridge between the OPC7 CPU core and an external 8-bit asynchronous SRAM, plus an optional 32-bit I/O handshake port. It captures each CPU bus request from the core's `*_nxt` look-ahead outputs and performs four byte accesses, little-endian. It assembles or splits the 32-bit word and stalls the core via `clken` until the word is complete. Sits directly below the CPU: it drives the core's `din` and `clken` and consumes its bus outputs.

---
 rtl/opc7_pkg.sv | 21 ++
 rtl/opc7_membus_io.sv | 48 ++++
 rtl/opc7_membus.sv | 184 ++++++++++++++++++
 tb/tb_opc7_membus.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opc7_pkg.sv
// ----------------------------------------------------------------------------
// opc7_pkg
// Shared definitions for the OPC7 memory bus bridge: bridge state encoding,
// word geometry and the width of the wait-state counter.
// ----------------------------------------------------------------------------
package opc7_pkg;

    // Bytes transferred per 32-bit CPU word on the 8-bit SRAM.
    localparam int BYTES_PER_WORD = 4;

    // Width of the per-byte wait-state counter (WAIT_STATES range 0..7).
    localparam int WS_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,   // no access in flight, CPU running
        ST_MEM,    // four byte accesses to the SRAM
        ST_IO,     // I/O handshake (or single-cycle dummy access)
        ST_DONE    // CPU consumes the result on this edge
    } bus_state_t;

endpackage

// File: rtl/opc7_membus_io.sv
// ----------------------------------------------------------------------------
// opc7_membus_io
// Request/acknowledge handshake for the 32-bit I/O port of opc7_membus.
// Only instantiated when OPC7_MEMBUS_IO_EN is defined.
//
// Ports:
//   clk, reset_b          clock, asynchronous active-low reset
//   start                 capture a new I/O request this edge
//   rnw, addr, wdata      request attributes, sampled on start
//   done                  handshake completes on this edge (io_req & io_ack)
//   io_req/io_rnw/io_addr/io_wdata  registered request, held until ack
//   io_ack                acknowledge from the I/O target
// ----------------------------------------------------------------------------
module opc7_membus_io (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        start,
    input  logic        rnw,
    input  logic [19:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic        io_req,
    output logic        io_rnw,
    output logic [19:0] io_addr,
    output logic [31:0] io_wdata,
    input  logic        io_ack
);

    // An ack only counts while a request is outstanding.
    assign done = io_req & io_ack;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            io_req   <= 1'b0;
            io_rnw   <= 1'b0;
            io_addr  <= '0;
            io_wdata <= '0;
        end else if (start) begin
            io_req   <= 1'b1;
            io_rnw   <= rnw;
            io_addr  <= addr;
            io_wdata <= wdata;
        end else if (done) begin
            io_req   <= 1'b0;
        end
    end

endmodule

// File: rtl/opc7_membus.sv
// ----------------------------------------------------------------------------
// opc7_membus
// Bridge between the OPC7 CPU core and an 8-bit asynchronous SRAM. Each CPU
// bus request (taken from the core's *_nxt look-ahead outputs) becomes four
// little-endian byte accesses; the CPU is stalled through clken until the
// 32-bit word is complete. With OPC7_MEMBUS_IO_EN defined, vio_nxt accesses
// go to a 32-bit req/ack I/O port; otherwise they complete as a one-cycle
// dummy access (reads return 0, writes are dropped).
//
// Parameter:
//   WAIT_STATES  extra cycles per byte access (0..7)
// Ports:
//   clk, reset_b                      clock, asynchronous active-low reset
//   vpa_nxt, vda_nxt, vio_nxt, rnw_nxt, address_nxt, dout_nxt
//                                     CPU next-cycle bus request
//   clken                             CPU clock enable (0 = stall)
//   din                               read data to the CPU
//   mem_addr, mem_wdata, mem_rdata    SRAM byte address/data
//   mem_ce_b, mem_oe_b, mem_we_b      SRAM strobes, active-low, registered
//   io_* (OPC7_MEMBUS_IO_EN only)     I/O handshake port
// ----------------------------------------------------------------------------
module opc7_membus
    import opc7_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        vpa_nxt,
    input  logic        vda_nxt,
    input  logic        vio_nxt,
    input  logic        rnw_nxt,
    input  logic [19:0] address_nxt,
    input  logic [31:0] dout_nxt,
    output logic        clken,
    output logic [31:0] din,
    output logic [21:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_ce_b,
    output logic        mem_oe_b,
    output logic        mem_we_b,
`ifdef OPC7_MEMBUS_IO_EN
    output logic        io_req,
    output logic        io_rnw,
    output logic [19:0] io_addr,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata,
    input  logic        io_ack,
`endif
    input  logic [7:0]  mem_rdata
);

    localparam logic [WS_W-1:0] WS_LAST  = WS_W'(WAIT_STATES);
    localparam logic [1:0]      LAST_IDX = 2'(BYTES_PER_WORD - 1);

    bus_state_t      state, state_nxt;
    logic [WS_W-1:0] wcnt, wcnt_nxt;
    logic [1:0]      idx, idx_nxt;
    logic            capture, slot_end, io_done;
    logic [19:0]     addr_q, addr_sel;
    logic [31:0]     data_q, data_sel;
    logic            rnw_q, rnw_sel;
    logic [31:0]     io_rd_word;

    // On the capture edge the latched copies are not yet valid, so the
    // registered outputs take the request straight from the CPU.
    assign addr_sel = capture ? address_nxt : addr_q;
    assign data_sel = capture ? dout_nxt    : data_q;
    assign rnw_sel  = capture ? rnw_nxt     : rnw_q;

`ifdef OPC7_MEMBUS_IO_EN
    opc7_membus_io u_io (
        .clk      (clk),
        .reset_b  (reset_b),
        .start    (capture && (state_nxt == ST_IO)),
        .rnw      (rnw_nxt),
        .addr     (address_nxt),
        .wdata    (dout_nxt),
        .done     (io_done),
        .io_req   (io_req),
        .io_rnw   (io_rnw),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_ack   (io_ack)
    );
    assign io_rd_word = io_rdata;
`else
    // No I/O port: the access finishes after one stall cycle and reads 0.
    assign io_done    = 1'b1;
    assign io_rd_word = '0;
`endif

    always_ff @(posedge clk or negedge reset_b) begin
        // NOTE: every sequential assignment is non-blocking so all registers
        // update from the same pre-edge values, independent of block order.
        if (!reset_b) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // skipped one would infer a latch.
        state_nxt = state;
        wcnt_nxt  = wcnt;
        idx_nxt   = idx;
        capture   = 1'b0;
        slot_end  = (wcnt == WS_LAST);
        case (state)
            ST_IDLE, ST_DONE: begin
                // DONE is the CPU's consuming edge and can take the next
                // request directly, so back-to-back accesses lose no cycle.
                wcnt_nxt = '0;
                idx_nxt  = '0;
                if (vio_nxt) begin
                    state_nxt = ST_IO;
                    capture   = 1'b1;
                end else if (vpa_nxt || vda_nxt) begin
                    state_nxt = ST_MEM;
                    capture   = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_MEM: begin
                if (slot_end) begin
                    wcnt_nxt = '0;
                    idx_nxt  = idx + 2'd1;
                    if (idx == LAST_IDX) state_nxt = ST_DONE;
                end else begin
                    wcnt_nxt = wcnt + 1'b1;
                end
            end
            ST_IO: begin
                if (io_done) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        // NOTE: the whole datapath is reset, so an access aborted by reset
        // leaves no partial word in din and no strobe asserted.
        if (!reset_b) begin
            wcnt      <= '0;
            idx       <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            rnw_q     <= 1'b0;
            clken     <= 1'b1;
            din       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_ce_b  <= 1'b1;
            mem_oe_b  <= 1'b1;
            mem_we_b  <= 1'b1;
        end else begin
            wcnt <= wcnt_nxt;
            idx  <= idx_nxt;
            if (capture) begin
                addr_q <= address_nxt;
                data_q <= dout_nxt;
                rnw_q  <= rnw_nxt;
            end

            // Outputs are registered from the next state so they change only
            // on clock edges and stay stable across each byte slot.
            clken    <= (state_nxt == ST_IDLE) || (state_nxt == ST_DONE);
            mem_ce_b <= (state_nxt != ST_MEM);
            mem_oe_b <= !((state_nxt == ST_MEM) && rnw_sel);
            mem_we_b <= !((state_nxt == ST_MEM) && !rnw_sel);
            if (state_nxt == ST_MEM) begin
                mem_addr  <= {addr_sel, idx_nxt};
                mem_wdata <= data_sel[{idx_nxt, 3'b000} +: 8];
            end

            // Read byte is taken on the last cycle of its slot.
            if ((state == ST_MEM) && slot_end && rnw_q)
                din[{idx, 3'b000} +: 8] <= mem_rdata;
            if ((state == ST_IO) && io_done && rnw_q)
                din <= io_rd_word;
        end
    end

endmodule

// File: tb/tb_opc7_membus.sv
// ----------------------------------------------------------------------------
// tb_opc7_membus
// Self-checking bench for opc7_membus. Two instances: u0 with WAIT_STATES=1
// and u1 with WAIT_STATES=0. The bench plays the CPU, models the SRAM as a
// byte array and predicts results from a separate reference byte memory.
// Works with or without OPC7_MEMBUS_IO_EN.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_opc7_membus;

    localparam int WS0 = 1;
    localparam int WS1 = 0;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        vpa     [2];
    logic        vda     [2];
    logic        vio     [2];
    logic        rnw_n   [2];
    logic [19:0] addr_n  [2];
    logic [31:0] dout_n  [2];
    logic        clken   [2];
    logic [31:0] din     [2];
    logic [21:0] mem_addr[2];
    logic [7:0]  mem_wdata[2];
    logic [7:0]  mem_rdata[2];
    logic        ce_b    [2];
    logic        oe_b    [2];
    logic        we_b    [2];
`ifdef OPC7_MEMBUS_IO_EN
    logic        io_req  [2];
    logic        io_rnw  [2];
    logic [19:0] io_addr [2];
    logic [31:0] io_wdata[2];
    logic [31:0] io_rdata[2];
    logic        io_ack  [2];
`endif

    always #5 clk = ~clk;

    opc7_membus #(.WAIT_STATES(WS0)) u0 (
        .clk(clk), .reset_b(reset_b),
        .vpa_nxt(vpa[0]), .vda_nxt(vda[0]), .vio_nxt(vio[0]), .rnw_nxt(rnw_n[0]),
        .address_nxt(addr_n[0]), .dout_nxt(dout_n[0]),
        .clken(clken[0]), .din(din[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_ce_b(ce_b[0]), .mem_oe_b(oe_b[0]), .mem_we_b(we_b[0]),
`ifdef OPC7_MEMBUS_IO_EN
        .io_req(io_req[0]), .io_rnw(io_rnw[0]), .io_addr(io_addr[0]),
        .io_wdata(io_wdata[0]), .io_rdata(io_rdata[0]), .io_ack(io_ack[0]),
`endif
        .mem_rdata(mem_rdata[0])
    );

    opc7_membus #(.WAIT_STATES(WS1)) u1 (
        .clk(clk), .reset_b(reset_b),
        .vpa_nxt(vpa[1]), .vda_nxt(vda[1]), .vio_nxt(vio[1]), .rnw_nxt(rnw_n[1]),
        .address_nxt(addr_n[1]), .dout_nxt(dout_n[1]),
        .clken(clken[1]), .din(din[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_ce_b(ce_b[1]), .mem_oe_b(oe_b[1]), .mem_we_b(we_b[1]),
`ifdef OPC7_MEMBUS_IO_EN
        .io_req(io_req[1]), .io_rnw(io_rnw[1]), .io_addr(io_addr[1]),
        .io_wdata(io_wdata[1]), .io_rdata(io_rdata[1]), .io_ack(io_ack[1]),
`endif
        .mem_rdata(mem_rdata[1])
    );

    // ---------------- SRAM model and reference memory ----------------
    bit [7:0]    sram    [int];   // written by the DUT strobes
    bit [7:0]    ref_mem [int];   // written by the bench's own model
    logic [31:0] exp_din [2];
    int          n_pass  = 0;
    int          n_total = 0;

    function automatic int ws_of(input int u);
        return (u == 0) ? WS0 : WS1;
    endfunction

    function automatic int key(input int u, input logic [21:0] a);
        return (u << 24) | int'(a);
    endfunction

    function automatic bit [7:0] init_byte(input logic [21:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    function automatic bit [7:0] sram_rd(input int u, input logic [21:0] a);
        int k;
        k = key(u, a);
        return sram.exists(k) ? sram[k] : init_byte(a);
    endfunction

    function automatic bit [7:0] ref_rd(input int u, input logic [21:0] a);
        int k;
        k = key(u, a);
        return ref_mem.exists(k) ? ref_mem[k] : init_byte(a);
    endfunction

    // Little-endian word assembled from the reference bytes.
    function automatic logic [31:0] ref_word(input int u, input logic [19:0] wa);
        logic [31:0] w;
        logic [1:0]  b2;
        for (int b = 0; b < 4; b++) begin
            b2 = 2'(b);
            w[8*b +: 8] = ref_rd(u, {wa, b2});
        end
        return w;
    endfunction

    function automatic logic [31:0] sram_word(input int u, input logic [19:0] wa);
        logic [31:0] w;
        logic [1:0]  b2;
        for (int b = 0; b < 4; b++) begin
            b2 = 2'(b);
            w[8*b +: 8] = sram_rd(u, {wa, b2});
        end
        return w;
    endfunction

    // Asynchronous SRAM: address/strobes are stable through each slot, so
    // updating mid-cycle presents valid data before the sampling edge.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (ce_b[u] === 1'b0 && we_b[u] === 1'b0)
                sram[key(u, mem_addr[u])] = mem_wdata[u];
            mem_rdata[u] = (ce_b[u] === 1'b0 && oe_b[u] === 1'b0)
                           ? sram_rd(u, mem_addr[u]) : 8'h00;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One CPU bus access. Entered at a negedge with clken high; returns at
    // the negedge of the DONE cycle, so another call right away is a
    // back-to-back request. Counts stall cycles and strobe/port errors.
    task automatic txn(input int u, input bit io, input bit rnw,
                       input logic [19:0] a, input logic [31:0] d,
                       input int ack_dly, input logic [31:0] io_rd,
                       output int stall, output logic [31:0] din_out,
                       output int bad, output int reqc);
        int         ws, slot;
        logic [1:0] s2;
        bit         fin;
        ws = ws_of(u);
        stall = 0; bad = 0; reqc = 0; fin = 1'b0;
        vio[u] = io; vpa[u] = !io; vda[u] = 1'b0;
        rnw_n[u] = rnw; addr_n[u] = a; dout_n[u] = d;
`ifdef OPC7_MEMBUS_IO_EN
        io_rdata[u] = io_rd;
`endif
        @(posedge clk);
        #1;
        vio[u] = 1'b0; vpa[u] = 1'b0;
        addr_n[u] = 20'($urandom); dout_n[u] = $urandom;  // must already be latched
        while (!fin) begin
            @(negedge clk);
            if (clken[u] === 1'b1 || stall >= 200) begin
                fin = 1'b1;
            end else begin
                stall++;
                if (!io) begin
                    slot = (stall - 1) / (ws + 1);
                    s2   = 2'(slot);
                    if (ce_b[u] !== 1'b0 || oe_b[u] !== !rnw || we_b[u] !== rnw ||
                        mem_addr[u] !== {a, s2} ||
                        (!rnw && mem_wdata[u] !== d[8*s2 +: 8]))
                        bad++;
                end else begin
                    if (ce_b[u] !== 1'b1 || oe_b[u] !== 1'b1 || we_b[u] !== 1'b1)
                        bad++;
`ifdef OPC7_MEMBUS_IO_EN
                    if (io_req[u] === 1'b1) begin
                        reqc++;
                        if (io_rnw[u] !== rnw || io_addr[u] !== a || io_wdata[u] !== d)
                            bad++;
                    end else begin
                        bad++;
                    end
                    io_ack[u] = (reqc > ack_dly);
`endif
                end
            end
        end
`ifdef OPC7_MEMBUS_IO_EN
        io_ack[u] = 1'b0;
        if (io_req[u] !== 1'b0) bad++;
`endif
        if (ce_b[u] !== 1'b1 || oe_b[u] !== 1'b1 || we_b[u] !== 1'b1) bad++;
        din_out = din[u];
    endtask

    task automatic do_mem(input int u, input bit rnw, input logic [19:0] a,
                          input logic [31:0] d, input string tag);
        int          stall, bad, reqc;
        logic [31:0] dout;
        logic [1:0]  b2;
        txn(u, 1'b0, rnw, a, d, 0, 32'h0, stall, dout, bad, reqc);
        if (rnw) begin
            exp_din[u] = ref_word(u, a);
        end else begin
            for (int b = 0; b < 4; b++) begin
                b2 = 2'(b);
                ref_mem[key(u, {a, b2})] = d[8*b +: 8];
            end
            check({tag, "_sram"}, 64'(sram_word(u, a)), 64'(ref_word(u, a)));
        end
        check({tag, "_stall"}, 64'(stall), 64'(4 * (ws_of(u) + 1)));
        check({tag, "_din"},   64'(dout),  64'(exp_din[u]));
        check({tag, "_bus"},   64'(bad),   64'd0);
    endtask

    task automatic do_io(input int u, input bit rnw, input logic [19:0] a,
                         input logic [31:0] d, input int dly,
                         input logic [31:0] rd, input string tag);
        int          stall, bad, reqc, exp_stall;
        logic [31:0] dout;
        txn(u, 1'b1, rnw, a, d, dly, rd, stall, dout, bad, reqc);
`ifdef OPC7_MEMBUS_IO_EN
        exp_stall = dly + 1;
        if (rnw) exp_din[u] = rd;
        check({tag, "_reqcyc"}, 64'(reqc), 64'(dly + 1));
`else
        exp_stall = 1;
        if (rnw) exp_din[u] = 32'h0;
`endif
        check({tag, "_stall"}, 64'(stall), 64'(exp_stall));
        check({tag, "_din"},   64'(dout),  64'(exp_din[u]));
        check({tag, "_bus"},   64'(bad),   64'd0);
    endtask

    initial begin
        int          cnt;
        int          kind;
        bit          r;
        logic [19:0] ra;
        logic [31:0] rd_v, rd_io;
        int          dly;

        reset_b = 1'b0;
        for (int u = 0; u < 2; u++) begin
            vpa[u] = 1'b0; vda[u] = 1'b0; vio[u] = 1'b0; rnw_n[u] = 1'b1;
            addr_n[u] = '0; dout_n[u] = '0; mem_rdata[u] = '0; exp_din[u] = '0;
`ifdef OPC7_MEMBUS_IO_EN
            io_ack[u] = 1'b0; io_rdata[u] = '0;
`endif
        end
        sram[key(0, 22'd0)] = 8'h11; sram[key(0, 22'd1)] = 8'h22;
        sram[key(0, 22'd2)] = 8'h33; sram[key(0, 22'd3)] = 8'h44;
        ref_mem[key(0, 22'd0)] = 8'h11; ref_mem[key(0, 22'd1)] = 8'h22;
        ref_mem[key(0, 22'd2)] = 8'h33; ref_mem[key(0, 22'd3)] = 8'h44;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_clken", 64'(clken[0]),    64'd1);
        check("rst_din",   64'(din[0]),      64'd0);
        check("rst_ce",    64'(ce_b[0]),     64'd1);
        check("rst_oe",    64'(oe_b[0]),     64'd1);
        check("rst_we",    64'(we_b[0]),     64'd1);
        check("rst_addr",  64'(mem_addr[0]), 64'd0);
        check("rst_wdata", 64'(mem_wdata[0]),64'd0);
`ifdef OPC7_MEMBUS_IO_EN
        check("rst_ioreq", 64'(io_req[0]),   64'd0);
`endif
        reset_b = 1'b1;
        @(negedge clk);
        check("idle_clken", 64'(clken[0]), 64'd1);

        // Fetch from word 0, then a store, then back-to-back fetches (WS=0)
        do_mem(0, 1'b1, 20'h00000, 32'h0, "fetch0");
        check("fetch0_word", 64'(din[0]), 64'h44332211);
        do_mem(0, 1'b0, 20'h00010, 32'hDEADBEEF, "store");
        check("store_bytes", 64'(sram_word(0, 20'h00010)), 64'hDEADBEEF);
        do_mem(1, 1'b1, 20'h00005, 32'h0, "b2b_a");
        do_mem(1, 1'b1, 20'h00006, 32'h0, "b2b_b");

        // I/O read with delayed ack, zero-delay write
        do_io(0, 1'b1, 20'h000FE, 32'h0, 3, 32'hCAFEF00D, "ioread");
        do_io(0, 1'b0, 20'h00003, 32'h12345678, 0, 32'h0, "iowrite");

        // Reset during byte 2 of a write, after a read leaves din non-zero
        do_mem(0, 1'b1, 20'h00000, 32'h0, "pre_rst");
        vpa[0] = 1'b1; rnw_n[0] = 1'b0; addr_n[0] = 20'h00020; dout_n[0] = 32'h0BADF00D;
        @(posedge clk);
        #1;
        vpa[0] = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(ce_b[0] === 1'b0 && mem_addr[0][1:0] === 2'd2) && cnt < 20);
        check("abort_byte2", 64'(mem_addr[0]), 64'({20'h00020, 2'd2}));
        #2 reset_b = 1'b0;
        #1;
        check("abort_we",    64'(we_b[0]),  64'd1);
        check("abort_ce",    64'(ce_b[0]),  64'd1);
        check("abort_oe",    64'(oe_b[0]),  64'd1);
        check("abort_clken", 64'(clken[0]), 64'd1);
        check("abort_din",   64'(din[0]),   64'd0);
        exp_din[0] = '0;
        exp_din[1] = '0;
        @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        do_mem(0, 1'b0, 20'h00020, 32'h0BADF00D, "restart");

        // Randomized mix against the reference memory
        for (int i = 0; i < 24; i++) begin
            kind  = $urandom_range(0, 9);
            r     = 1'($urandom_range(0, 1));
            ra    = 20'h00100 + 20'($urandom_range(0, 7));
            rd_v  = $urandom;
            rd_io = $urandom;
            dly   = $urandom_range(0, 3);
            if (kind < 7) do_mem(0, r, ra, rd_v, "rnd_mem");
            else          do_io(0, r, ra, rd_v, dly, rd_io, "rnd_io");
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
